// File: rtl/user_rom_reader_pkg.sv
// Shared types for the user ROM byte reader: FSM states, serializer geometry and
// the default OBI request/response structs used on the manager port.
package user_rom_reader_pkg;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned WordWidth    = 8 * BytesPerWord;

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_REQ,
    RD_WAIT,
    RD_DRAIN,
    RD_DONE
  } rd_state_e;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [0:0]  aid;
  } rom_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } rom_obi_rsp_t;

endpackage

// File: rtl/user_rom_reader_ser.sv
// 32-to-8 serializer: loads a word and hands its bytes out MSB-first over a
// valid/ready handshake; last_o marks the handshake of the final byte.
module user_rom_reader_ser
  import user_rom_reader_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [WordWidth-1:0] word_i,
  output logic [7:0]           byte_o,
  output logic                 byte_valid_o,
  input  logic                 byte_ready_i,
  output logic                 last_o
);

  localparam int unsigned IdxW = $clog2(BytesPerWord);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BytesPerWord - 1);

  logic [WordWidth-1:0] word_q;
  logic [IdxW-1:0]      idx_q;
  logic                 valid_q;
  logic                 hs;

  assign hs = valid_q & byte_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      word_q  <= word_i;
      idx_q   <= '0;
      valid_q <= 1'b1;
    end else if (hs) begin
      idx_q <= idx_q + 1'b1;
      if (idx_q == LastIdx) valid_q <= 1'b0;
    end
  end

  // Byte 0 is the most significant lane, so shift down by the lanes below it.
  assign byte_o       = 8'(word_q >> {LastIdx - idx_q, 3'b000});
  assign byte_valid_o = valid_q;
  assign last_o       = hs && (idx_q == LastIdx);

endmodule

// File: rtl/user_rom_reader.sv
// OBI manager that reads NumWords consecutive ROM words on a start pulse and
// streams their bytes MSB-first; a bus error aborts the run with a sticky flag.
module user_rom_reader
  import user_rom_reader_pkg::*;
#(
  parameter type         obi_req_t = rom_obi_req_t,
  parameter type         obi_rsp_t = rom_obi_rsp_t,
  parameter logic [31:0] BaseAddr  = 32'h2000_0000,
  parameter int unsigned NumWords  = 8
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     start_i,
  output logic     busy_o,
  output logic     done_o,
  output logic     err_o,
  output obi_req_t obi_req_o,
  input  obi_rsp_t obi_rsp_i,
  output logic [7:0] byte_o,
  output logic     byte_valid_o,
  input  logic     byte_ready_i
);

  localparam int unsigned IdxW = $clog2(NumWords) + 1;
  localparam logic [IdxW-1:0] LastWord = IdxW'(NumWords - 1);

  rd_state_e       state_q;
  logic [IdxW-1:0] word_idx_q;
  logic            err_q;
  logic            ser_load;
  logic            ser_last;
  logic [31:0]     word_addr;

  assign word_addr = BaseAddr + (32'(word_idx_q) << 2);
  assign ser_load  = (state_q == RD_WAIT) && obi_rsp_i.rvalid && !obi_rsp_i.err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= RD_IDLE;
      word_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      unique case (state_q)
        RD_IDLE: if (start_i) begin
          err_q      <= 1'b0;
          word_idx_q <= '0;
          state_q    <= RD_REQ;
        end
        RD_REQ: if (obi_rsp_i.gnt) state_q <= RD_WAIT;
        RD_WAIT: if (obi_rsp_i.rvalid) begin
          if (obi_rsp_i.err) begin
            err_q   <= 1'b1;
            state_q <= RD_DONE;
          end else begin
            state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: if (ser_last) begin
          if (word_idx_q == LastWord) begin
            state_q <= RD_DONE;
          end else begin
            word_idx_q <= word_idx_q + 1'b1;
            state_q    <= RD_REQ;
          end
        end
        RD_DONE: state_q <= RD_IDLE;
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  always_comb begin
    obi_req_o      = '0;
    obi_req_o.req  = (state_q == RD_REQ);
    obi_req_o.addr = word_addr;
    obi_req_o.we   = 1'b0;
    obi_req_o.be   = 4'hF;
  end

  assign busy_o = (state_q != RD_IDLE);
  assign done_o = (state_q == RD_DONE);
  assign err_o  = err_q;

  user_rom_reader_ser u_ser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (ser_load),
    .word_i      (obi_rsp_i.rdata),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i),
    .last_o      (ser_last)
  );

endmodule

// File: tb/tb_user_rom_reader.sv
// Self-checking bench for user_rom_reader: behavioural ROM subordinate with
// configurable grant/response delays and error injection, plus a byte sink.
module tb_user_rom_reader;
  import user_rom_reader_pkg::*;

  localparam logic [31:0] Base = 32'h2000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic         busy_o, done_o, err_o;
  rom_obi_req_t obi_req_o;
  rom_obi_rsp_t obi_rsp_i = '0;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         byte_ready_i = 1'b1;

  logic         start1 = 1'b0;
  logic         busy1, done1, err1, valid1;
  rom_obi_req_t req1;
  rom_obi_rsp_t rsp1 = '0;
  logic [7:0]   byte1;

  user_rom_reader #(.BaseAddr(Base), .NumWords(8)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .obi_req_o(obi_req_o), .obi_rsp_i(obi_rsp_i), .byte_o(byte_o),
    .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i)
  );

  user_rom_reader #(.BaseAddr(Base), .NumWords(1)) u_one (
    .clk_i(clk), .rst_i(rst_i), .start_i(start1), .busy_o(busy1), .done_o(done1),
    .err_o(err1), .obi_req_o(req1), .obi_rsp_i(rsp1), .byte_o(byte1),
    .byte_valid_o(valid1), .byte_ready_i(1'b1)
  );

  string msg = "Kushal: Octpusues have 3 hearts!";

  function automatic logic [31:0] rom_word(input int w);
    int b;
    b = 4 * (w % 8);
    return {msg[b], msg[b+1], msg[b+2], msg[b+3]};
  endfunction

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Configuration written only by the test tasks
  int gnt_dly = 0, rd_dly = 0, err_word = -1;
  bit ready_rand = 1'b0;

  // Observations written only by the model process
  logic [7:0] got[$];
  int done_cnt = 0, done_cyc = -1, grants = 0, run_grants = 0;
  int stall_cnt = 0, stall_viol = 0, addr_viol = 0;
  int req_cycles = 0, pcnt = 0, pidx = 0;
  bit pend = 1'b0, prev_stall = 1'b0;
  logic [7:0]  prev_byte;
  logic [31:0] first_addr;
  logic [7:0] q1[$];
  int done1_cnt = 0, addr1_viol = 0;
  bit pend1 = 1'b0;

  always @(negedge clk) begin
    byte_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (prev_stall) begin
      stall_cnt++;
      if (!byte_valid_o || byte_o !== prev_byte) stall_viol++;
    end
    prev_stall = byte_valid_o && !byte_ready_i;
    prev_byte  = byte_o;
    if (byte_valid_o && byte_ready_i) got.push_back(byte_o);
    if (done_o) begin
      done_cnt++;
      done_cyc   = cyc;
      run_grants = 0;
    end

    obi_rsp_i = '0;
    if (pend) begin
      if (pcnt == 0) begin
        obi_rsp_i.rvalid = 1'b1;
        obi_rsp_i.rdata  = rom_word(pidx);
        obi_rsp_i.err    = (pidx == err_word);
        pend = 1'b0;
      end else pcnt--;
    end
    if (obi_req_o.req) begin
      if (req_cycles == 0) first_addr = obi_req_o.addr;
      else if (obi_req_o.addr !== first_addr) addr_viol++;
      if (obi_req_o.we !== 1'b0 || obi_req_o.be !== 4'hF) addr_viol++;
      req_cycles++;
      if (req_cycles > gnt_dly) begin
        obi_rsp_i.gnt = 1'b1;
        if (obi_req_o.addr !== Base + 32'(4 * run_grants)) addr_viol++;
        pidx = run_grants;
        pend = 1'b1;
        pcnt = rd_dly;
        grants++;
        run_grants++;
        req_cycles = 0;
      end
    end
    if (rst_i) run_grants = 0;

    rsp1 = '0;
    if (pend1) begin
      rsp1.rvalid = 1'b1;
      rsp1.rdata  = rom_word(0);
      pend1 = 1'b0;
    end
    if (req1.req) begin
      rsp1.gnt = 1'b1;
      pend1 = 1'b1;
      if (req1.addr !== Base) addr1_viol++;
    end
    if (valid1) q1.push_back(byte1);
    if (done1) done1_cnt++;
  end

  // Snapshots taken by do_run for relative checks
  int t0, g0, b0, d0, s0, sv0, a0;
  logic err_after_start;
  bit timed_out;

  task automatic do_run(input int gd, input int rd, input int ew, input bit rnd, input int poke);
    int n;
    gnt_dly = gd; rd_dly = rd; err_word = ew; ready_rand = rnd;
    @(negedge clk);
    g0 = grants; b0 = got.size(); d0 = done_cnt; s0 = stall_cnt; sv0 = stall_viol; a0 = addr_viol;
    start_i = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
    err_after_start = err_o;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      start_i = (poke > 0 && n == poke);
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    timed_out = (done_cnt == d0);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL run_timeout: done_o not seen within %0d cycles (required pulse)", n);
    end
    repeat (3) @(negedge clk);
    ready_rand = 1'b0;
  endtask

  task automatic check_bytes(input string name, input int nb);
    checks++;
    if (got.size() - b0 !== nb) begin
      errors++;
      $display("FAIL %s_count: got %0d bytes, required %0d", name, got.size() - b0, nb);
    end
    for (int i = 0; i < nb && b0 + i < got.size(); i++) begin
      checks++;
      if (got[b0+i] !== msg[i]) begin
        errors++;
        $display("FAIL %s_byte%0d: got 0x%02h, required 0x%02h", name, i, got[b0+i], msg[i]);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 6;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_o); end
    if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done_o); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, required 0", err_o); end
    if (byte_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", byte_valid_o); end
    if (byte_o !== 8'h00) begin errors++; $display("FAIL reset_byte: got 0x%02h, required 0x00", byte_o); end
    if (obi_req_o.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b, required 0", obi_req_o.req); end
    rst_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    do_run(0, 0, -1, 1'b0, 0);
    check_bytes("basic", 32);
    checks += 5;
    if (done_cyc !== t0 + 49) begin errors++; $display("FAIL basic_done_cycle: got t+%0d, required t+49", done_cyc - t0); end
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", done_cnt - d0); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL basic_err: got %b, required 0", err_o); end
    if (grants - g0 !== 8) begin errors++; $display("FAIL basic_grants: got %0d, required 8", grants - g0); end
    if (addr_viol - a0 !== 0) begin errors++; $display("FAIL basic_addr: got %0d violations, required 0", addr_viol - a0); end
  endtask

  task automatic test_backpressure;
    do_run(0, 0, -1, 1'b1, 0);
    check_bytes("bp", 32);
    checks += 3;
    if (stall_viol - sv0 !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls, required 0", stall_viol - sv0); end
    if (stall_cnt - s0 <= 0) begin errors++; $display("FAIL bp_stalls: got %0d stalled cycles, required >0", stall_cnt - s0); end
    if (grants - g0 !== 8) begin errors++; $display("FAIL bp_grants: got %0d, required 8", grants - g0); end
  endtask

  task automatic test_delays;
    do_run(3, 2, -1, 1'b0, 0);
    check_bytes("delay", 32);
    checks += 2;
    if (addr_viol - a0 !== 0) begin errors++; $display("FAIL delay_addr: got %0d violations, required 0", addr_viol - a0); end
    if (done_cyc !== t0 + 1 + 8 * (4 + 2 + 1 + 4)) begin
      errors++; $display("FAIL delay_done_cycle: got t+%0d, required t+89", done_cyc - t0);
    end
  endtask

  task automatic test_error;
    do_run(0, 0, 2, 1'b0, 0);
    check_bytes("err", 8);
    checks += 4;
    if (err_o !== 1'b1) begin errors++; $display("FAIL err_flag: got %b, required 1", err_o); end
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL err_done_count: got %0d, required 1", done_cnt - d0); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL err_idle: busy got %b, required 0", busy_o); end
    if (grants - g0 !== 3) begin errors++; $display("FAIL err_grants: got %0d, required 3", grants - g0); end
    do_run(0, 0, -1, 1'b0, 0);
    check_bytes("err_rerun", 32);
    checks += 2;
    if (err_after_start !== 1'b0) begin errors++; $display("FAIL err_clear: got %b, required 0", err_after_start); end
    if (err_o !== 1'b0) begin errors++; $display("FAIL err_rerun_flag: got %b, required 0", err_o); end
  endtask

  task automatic test_start_in_drain;
    do_run(0, 0, -1, 1'b0, 3);
    check_bytes("drain_start", 32);
    checks += 3;
    if (grants - g0 !== 8) begin errors++; $display("FAIL drain_start_grants: got %0d, required 8", grants - g0); end
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL drain_start_done: got %0d, required 1", done_cnt - d0); end
    if (done_cyc !== t0 + 49) begin errors++; $display("FAIL drain_start_cycle: got t+%0d, required t+49", done_cyc - t0); end
  endtask

  task automatic test_reset_in_wait;
    int n, gb, bb, db;
    gnt_dly = 0; rd_dly = 6; err_word = -1;
    @(negedge clk);
    gb = grants; bb = got.size(); db = done_cnt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (grants == gb && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (grants == gb) begin errors++; $display("FAIL rstwait_grant: no grant within %0d cycles", n); end
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    checks += 5;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rstwait_busy: got %b, required 0", busy_o); end
    if (done_o !== 1'b0) begin errors++; $display("FAIL rstwait_done: got %b, required 0", done_o); end
    if (byte_valid_o !== 1'b0) begin errors++; $display("FAIL rstwait_valid: got %b, required 0", byte_valid_o); end
    if (byte_o !== 8'h00) begin errors++; $display("FAIL rstwait_byte: got 0x%02h, required 0x00", byte_o); end
    if (obi_req_o.req !== 1'b0) begin errors++; $display("FAIL rstwait_req: got %b, required 0", obi_req_o.req); end
    rst_i = 1'b0;
    repeat (12) @(negedge clk);
    checks += 3;
    if (got.size() !== bb) begin errors++; $display("FAIL rstwait_late_bytes: got %0d bytes, required 0", got.size() - bb); end
    if (busy_o !== 1'b0) begin errors++; $display("FAIL rstwait_late_busy: got %b, required 0", busy_o); end
    if (done_cnt !== db) begin errors++; $display("FAIL rstwait_late_done: got %0d, required 0", done_cnt - db); end
    do_run(0, 0, -1, 1'b0, 0);
    check_bytes("rstwait_fresh", 32);
  endtask

  task automatic test_one_word;
    int n, qb;
    @(negedge clk);
    qb = q1.size();
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 0;
    while (done1_cnt == 0 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks += 3;
    if (done1_cnt !== 1) begin errors++; $display("FAIL one_done: got %0d pulses, required 1", done1_cnt); end
    if (q1.size() - qb !== 4) begin errors++; $display("FAIL one_count: got %0d bytes, required 4", q1.size() - qb); end
    if (addr1_viol !== 0) begin errors++; $display("FAIL one_addr: got %0d violations, required 0", addr1_viol); end
    for (int i = 0; i < 4 && qb + i < q1.size(); i++) begin
      checks++;
      if (q1[qb+i] !== msg[i]) begin
        errors++; $display("FAIL one_byte%0d: got 0x%02h, required 0x%02h", i, q1[qb+i], msg[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_delays;
    test_error;
    test_start_in_drain;
    test_reset_in_wait;
    test_one_word;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/user_rom_reader.md
# user_rom_reader

OBI manager that, on a start pulse, reads a fixed window of consecutive 32-bit words from the user ROM and emits their bytes MSB-first on a valid/ready byte stream. It sits directly upstream of the user ROM subordinate port in the user domain and turns the ROM's word-wide response into a byte feed for a UART or display sink. One transaction outstanding at a time; bus errors abort the run and raise a sticky flag.

## Interface
- ObiCfg, obi_pkg::ObiDefaultConfig, OBI configuration for the manager port
- obi_req_t, logic, OBI request struct type
- obi_rsp_t, logic, OBI response struct type
- BaseAddr, 32'h2000_0000, byte address of the first word; must be word-aligned
- NumWords, 8, words read per run; range 1..256

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start pulse; sampled only in IDLE
- busy_o  out  1  high from the cycle after an accepted start until DONE
- done_o  out  1  one-cycle pulse at the end of every run, normal or aborted
- err_o  out  1  sticky bus error; cleared by the next accepted start
- obi_req_o  out  obi_req_t  manager request
- obi_rsp_i  in  obi_rsp_t  subordinate response
- byte_o  out  8  output byte
- byte_valid_o  out  1  byte_o valid
- byte_ready_i  in  1  sink ready

## Operation
- States: IDLE, REQ, WAIT, DRAIN, DONE.
- IDLE: start_i=1 → clear err_o, word_idx=0, go to REQ. start_i in any other state is ignored.
- REQ: req=1, addr=BaseAddr+4*word_idx, we=0, be=4'hF, wdata=0, aid=0. All a-fields are held stable while req=1. On gnt → WAIT; req drops in the following cycle.
- WAIT: req=0. On rvalid with err=0 → latch rdata into word_q, byte_idx=0, go to DRAIN. On rvalid with err=1 → err_o=1, go to DONE; no bytes from that word are emitted.
- DRAIN: byte_valid_o=1, byte_o=word_q[31-8*byte_idx -: 8]. Each handshake (valid&ready) advances byte_idx. After the handshake at byte_idx=3: if word_idx=NumWords-1 → DONE, else word_idx+1 → REQ.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- rvalid outside WAIT is ignored. word_idx is $clog2(NumWords)+1 bits wide, so no wrap at 256.
- Reset in any state: FSM to IDLE, all outputs 0, req=0. An in-flight response arriving after reset is ignored.

## Timing
- Reset values: busy_o=0, done_o=0, err_o=0, byte_valid_o=0, byte_o=0, obi_req_o.req=0.
- With start_i at cycle t, immediate gnt, rvalid one cycle after gnt, and byte_ready_i tied high:
  - req at t+1
  - rvalid at t+2
  - bytes at t+3..t+6
  - next req at t+7
- Each word takes 6 cycles, so NumWords=8 takes 48 cycles.
- done_o is asserted in the cycle after the final byte handshake.
- Delayed gnt stretches REQ; delayed rvalid stretches WAIT; backpressure stretches DRAIN, with byte_o held stable while byte_valid_o=1 and byte_ready_i=0.
- busy_o is 0 in IDLE and 1 in REQ/WAIT/DRAIN/DONE.
- All outputs are registered or decoded directly from state; there is no combinational path from byte_ready_i to obi_req_o.

## Structure
- user_rom_reader_pkg holds the state enum typedef (rd_state_e) and the byte-lane constant BytesPerWord=4.
- Sub-module user_rom_reader_ser: the 32-to-8 serializer (load strobe, word register, byte index, valid/ready, last-byte flag). The FSM instantiates it.

## Test plan
- Start with the ROM attached, ready tied high → 32 bytes "Kushal: Octpusues have 3 hearts!" (first 0x4B 0x75 0x73 0x68, last 0x21); done_o pulses once at t+49; err_o=0.
- byte_ready_i toggled pseudo-randomly → same 32 bytes in the same order; byte_o stable during every stalled cycle; no extra requests issued.
- Subordinate model with gnt delayed 3 cycles and rvalid delayed 2 cycles → addr stays at 0x2000_0000 while req is high before gnt; bytes correct; per-word spacing 4+2+1+4 cycles.
- Word 2 returned with err=1 → 8 bytes emitted, err_o=1, done_o pulse, return to IDLE; next start clears err_o.
- start_i pulsed while in DRAIN → ignored, byte count still 32; rst_i asserted in WAIT → all outputs 0 next edge, late rvalid ignored, fresh start succeeds.
- NumWords=1 → 4 bytes 0x4B 0x75 0x73 0x68, then done_o.
